// File: rtl/io_bist_pkg.sv
// io_bist_pkg: state encoding and default LFSR/MISR constants
// shared by the IO BIST harness and its stimulus generator.
package io_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } bist_state_e;

  localparam logic [7:0] DEF_TAPS = 8'hB8;
  localparam logic [7:0] DEF_SEED = 8'h01;

endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr: Galois LFSR stimulus generator with load/advance.
// Shifts right, folding TAPS in whenever bit 0 falls out.
module bist_lfsr
  import io_bist_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] step;

  assign step = (value >> 1) ^ (value[0] ? TAPS : '0);

  // Load has priority over advance; reset returns to the load value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= load_value;
    end else if (load) begin
      value <= load_value;
    end else if (advance) begin
      value <= step;
    end
  end

endmodule

// File: rtl/io_bist_harness.sv
// io_bist_harness: LFSR-driven IO BIST with latency-matched capture.
// Define IO_BIST_MISR_EN for a MISR signature; default is a modular sum.
module io_bist_harness
  import io_bist_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8,
  parameter int LATENCY = 1,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(DEF_SEED),
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_pat,
  input  logic [WIDTH-1:0]   expected,
  output logic [WIDTH-1:0]   stim_out,
  input  logic [WIDTH-1:0]   resp_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [WIDTH-1:0]   signature
);

  localparam logic [WIDTH-1:0] SEED_EFF =
    (SEED == '0) ? WIDTH'(1) : SEED;

  bist_state_e        state_q;
  bist_state_e        state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] num_q;
  logic [LATENCY-1:0] vpipe_q;
  logic [LATENCY-1:0] vpipe_d;
  logic [WIDTH-1:0]   sig_q;
  logic [WIDTH-1:0]   sig_nxt;
  logic [WIDTH-1:0]   hold_q;
  logic [WIDTH-1:0]   lfsr_val;
  logic               run_bit;
  logic               launch;
  logic               last_pat;
  logic               capture;
  logic               lfsr_load;
  logic               lfsr_adv;

  assign run_bit  = (state_q == S_RUN);
  assign vpipe_d  = LATENCY'({vpipe_q, run_bit});
  assign capture  = vpipe_q[LATENCY-1];
  assign last_pat = (count_q == num_q - COUNT_W'(1));
  assign launch   = start &&
                    (state_q == S_IDLE || state_q == S_DONE);

`ifdef IO_BIST_MISR_EN
  assign sig_nxt = (sig_q << 1)
                 ^ (sig_q[WIDTH-1] ? TAPS : '0)
                 ^ resp_in;
`else
  assign sig_nxt = sig_q + resp_in;
`endif

  bist_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lfsr_load),
    .advance    (lfsr_adv),
    .load_value (SEED_EFF),
    .value      (lfsr_val)
  );

  // State register; ena low freezes the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state and LFSR control.
  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_load = ena;
          state_d = (num_pat == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        lfsr_adv = ena;
        if (last_pat) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (vpipe_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pattern count, valid pipe, held stimulus and signature.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      num_q   <= '0;
      vpipe_q <= '0;
      sig_q   <= '0;
      hold_q  <= '0;
    end else if (ena) begin
      vpipe_q <= vpipe_d;
      if (launch) begin
        count_q <= '0;
        num_q   <= num_pat;
        sig_q   <= '0;
        hold_q  <= '0;
      end else begin
        if (run_bit) begin
          count_q <= count_q + COUNT_W'(1);
          hold_q  <= lfsr_val;
        end
        if (capture) sig_q <= sig_nxt;
      end
    end
  end

  assign stim_out  = run_bit ? lfsr_val : hold_q;
  assign busy      = (state_q == S_RUN) ||
                     (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (sig_q == expected);
  assign signature = sig_q;

endmodule

// File: tb/tb_io_bist_harness.sv
// tb_io_bist_harness: directed checks of the IO BIST harness.
// Device model returns stim_out delayed one enabled cycle.
module tb_io_bist_harness;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] num_pat;
  logic [7:0] expected;
  logic [7:0] stim_out;
  logic [7:0] resp_in = 8'h00;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;

  int total = 0;
  int bad = 0;

  logic [7:0] pat_tab [0:4] =
    '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};

  logic [7:0] seen [0:31];
  int         nseen;
  int         nbusy;
  bit         tmo;

  io_bist_harness dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .num_pat   (num_pat),
    .expected  (expected),
    .stim_out  (stim_out),
    .resp_in   (resp_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ena) resp_in <= stim_out;

  function automatic logic [7:0] sig_model(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) begin
`ifdef IO_BIST_MISR_EN
      s = (s << 1) ^ (s[7] ? 8'hB8 : 8'h00) ^ pat_tab[i];
`else
      s = s + pat_tab[i];
`endif
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] n,
                      input logic [7:0] exp_sig);
    num_pat  = n;
    expected = exp_sig;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic watch();
    int guard = 0;
    nseen = 0;
    nbusy = 0;
    tmo   = 1'b0;
    while (!done && guard < 300) begin
      if (busy) begin
        nbusy++;
        if (nseen < 32) seen[nseen] = stim_out;
        nseen++;
      end
      tick();
      guard++;
    end
    tmo = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    num_pat = 8'd0;
    expected = 8'd0;
    repeat (3) tick();
    total++;
    if (stim_out !== 8'h00) begin
      bad++;
      $display("FAIL rst_stim got=%h want=00", stim_out);
    end
    total++;
    if ({busy, done, pass} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b want=000",
               {busy, done, pass});
    end
    total++;
    if (signature !== 8'h00) begin
      bad++;
      $display("FAIL rst_sig got=%h want=00", signature);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_run3(input logic [7:0] exp_sig,
                           input logic want_pass);
    logic [7:0] ref3;
`ifdef IO_BIST_MISR_EN
    ref3 = sig_model(3);
`else
    ref3 = 8'h15;
`endif
    kick(8'd3, exp_sig);
    watch();
    total++;
    if (tmo) begin
      bad++;
      $display("FAIL run3_timeout got=busy want=done");
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (seen[i] !== pat_tab[i]) begin
        bad++;
        $display("FAIL run3_stim%0d got=%h want=%h",
                 i, seen[i], pat_tab[i]);
      end
    end
    total++;
    if (seen[3] !== 8'h5C) begin
      bad++;
      $display("FAIL run3_drain_hold got=%h want=5c", seen[3]);
    end
    total++;
    if (nbusy !== 4) begin
      bad++;
      $display("FAIL run3_busy got=%0d want=4", nbusy);
    end
    total++;
    if (signature !== ref3) begin
      bad++;
      $display("FAIL run3_sig got=%h want=%h", signature, ref3);
    end
    total++;
    if ({done, pass} !== {1'b1, want_pass}) begin
      bad++;
      $display("FAIL run3_done_pass got=%b want=%b",
               {done, pass}, {1'b1, want_pass});
    end
    tick();
    total++;
    if (stim_out !== 8'h5C || done !== 1'b1) begin
      bad++;
      $display("FAIL run3_done_hold got=%h/%b want=5c/1",
               stim_out, done);
    end
  endtask

  task automatic test_zero();
    kick(8'd0, 8'h00);
    total++;
    if ({busy, done} !== 2'b01) begin
      bad++;
      $display("FAIL zero_flags got=%b want=01", {busy, done});
    end
    total++;
    if (signature !== 8'h00 || pass !== 1'b1) begin
      bad++;
      $display("FAIL zero_sig got=%h/%b want=00/1",
               signature, pass);
    end
  endtask

  task automatic test_run5();
    logic [7:0] ref5;
    ref5 = sig_model(5);
    kick(8'd5, ref5);
    watch();
    total++;
    if (tmo || nbusy !== 6) begin
      bad++;
      $display("FAIL run5_busy got=%0d want=6", nbusy);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (seen[i] !== pat_tab[i]) begin
        bad++;
        $display("FAIL run5_stim%0d got=%h want=%h",
                 i, seen[i], pat_tab[i]);
      end
    end
    total++;
    if (signature !== ref5 || pass !== 1'b1) begin
      bad++;
      $display("FAIL run5_sig got=%h/%b want=%h/1",
               signature, pass, ref5);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ref3;
    ref3 = sig_model(3);
    kick(8'd5, 8'h00);
    tick();
    total++;
    if (stim_out !== 8'hB8 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got=%h/%b want=b8/1",
               stim_out, busy);
    end
    rst_n = 1'b0;
    ena = 1'b0;
    tick();
    total++;
    if ({stim_out, busy, done, pass, signature} !== '0) begin
      bad++;
      $display("FAIL mid_rst got=%h/%b%b%b/%h want=0",
               stim_out, busy, done, pass, signature);
    end
    rst_n = 1'b1;
    ena = 1'b1;
    tick();
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL mid_idle got=%b want=00", {busy, done});
    end
    kick(8'd3, ref3);
    watch();
    total++;
    if (tmo || seen[0] !== 8'h01 || seen[2] !== 8'h5C) begin
      bad++;
      $display("FAIL mid_rerun_stim got=%h,%h want=01,5c",
               seen[0], seen[2]);
    end
    total++;
    if (signature !== ref3 || pass !== 1'b1) begin
      bad++;
      $display("FAIL mid_rerun_sig got=%h/%b want=%h/1",
               signature, pass, ref3);
    end
  endtask

  task automatic test_ena_freeze();
    logic [7:0] ref5;
    logic [7:0] snap;
    ref5 = sig_model(5);
    kick(8'd5, ref5);
    tick();
    start = 1'b1;
    num_pat = 8'd1;
    tick();
    start = 1'b0;
    total++;
    if (stim_out !== 8'h5C) begin
      bad++;
      $display("FAIL frz_start_ign got=%h want=5c", stim_out);
    end
    snap = signature;
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) start = 1'b1;
      tick();
      total++;
      if (stim_out !== 8'h5C || busy !== 1'b1 ||
          signature !== snap) begin
        bad++;
        $display("FAIL frz_hold%0d got=%h/%b/%h want=5c/1/%h",
                 i, stim_out, busy, signature, snap);
      end
    end
    start = 1'b0;
    ena = 1'b1;
    watch();
    total++;
    if (tmo || nbusy !== 4) begin
      bad++;
      $display("FAIL frz_busy got=%0d want=4", nbusy);
    end
    total++;
    if (seen[1] !== 8'h2E || seen[2] !== 8'h17) begin
      bad++;
      $display("FAIL frz_stim got=%h,%h want=2e,17",
               seen[1], seen[2]);
    end
    total++;
    if (signature !== ref5 || pass !== 1'b1) begin
      bad++;
      $display("FAIL frz_sig got=%h/%b want=%h/1",
               signature, pass, ref5);
    end
  endtask

  initial begin
    test_reset();
`ifdef IO_BIST_MISR_EN
    test_run3(sig_model(3), 1'b1);
    test_run3(sig_model(3) + 8'd1, 1'b0);
`else
    test_run3(8'h15, 1'b1);
    test_run3(8'h16, 1'b0);
`endif
    test_zero();
    test_run5();
    test_reset_mid();
    test_ena_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
